// File: rtl/jedro_1_wb_arbiter_if.sv
// Bus bundle between the execution units and the writeback arbiter:
// ALU/LSU results in, load-issue scoreboard, and register-file write port C out.
interface jedro_1_wb_arbiter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  localparam int NUM_REGISTERS = 2 ** REG_ADDR_WIDTH;

  logic                      alu_valid_i;
  logic [REG_ADDR_WIDTH-1:0] alu_rd_i;
  logic [DATA_WIDTH-1:0]     alu_data_i;
  logic                      lsu_valid_i;
  logic                      lsu_ready_o;
  logic [REG_ADDR_WIDTH-1:0] lsu_rd_i;
  logic [DATA_WIDTH-1:0]     lsu_data_i;
  logic                      ld_issue_i;
  logic [REG_ADDR_WIDTH-1:0] ld_issue_rd_i;
  logic [NUM_REGISTERS-1:0]  busy_o;
  logic [REG_ADDR_WIDTH-1:0] wpc_addr_o;
  logic [DATA_WIDTH-1:0]     wpc_data_o;
  logic                      wpc_we_o;

  // Arbiter side
  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  ld_issue_i, ld_issue_rd_i,
    output lsu_ready_o, busy_o,
    output wpc_addr_o, wpc_data_o, wpc_we_o
  );

  // Pipeline / register-file side
  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output ld_issue_i, ld_issue_rd_i,
    input  lsu_ready_o, busy_o,
    input  wpc_addr_o, wpc_data_o, wpc_we_o
  );
endinterface

// File: rtl/jedro_1_wb_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered LSU loads onto the
// register-file write port C, and tracks outstanding loads per register.
module jedro_1_wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 2
) (
  input logic                  clk_i,
  input logic                  rst_i,
  jedro_1_wb_arbiter_if.slave  wb
);
  localparam int NUM_REGISTERS = 2 ** REG_ADDR_WIDTH;
  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  // FIFO state (pointers carry an extra wrap bit)
  logic [PTR_W:0]            wr_ptr, rd_ptr;
  logic [PTR_W:0]            count;
  logic                      fifo_full, fifo_empty;
  logic [REG_ADDR_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     fifo_data [FIFO_DEPTH];

  logic                      lsu_accept, lsu_keep, alu_sel;
  logic                      push, pop;

  logic                      sel_vld_p0, sel_lsu_p0;
  logic [REG_ADDR_WIDTH-1:0] sel_addr_p0;
  logic [DATA_WIDTH-1:0]     sel_data_p0;

  logic                      vld_p1;
  logic [REG_ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0]     data_p1;

  logic [NUM_REGISTERS-1:0]  busy_q, set_mask, clr_mask;

  assign count      = wr_ptr - rd_ptr;
  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_empty = (wr_ptr == rd_ptr);

  assign wb.lsu_ready_o = !rst_i && !fifo_full;
  assign lsu_accept     = wb.lsu_valid_i && wb.lsu_ready_o;
  // rd=0 results are consumed here and never reach the port
  assign lsu_keep       = lsu_accept && (wb.lsu_rd_i != '0);
  assign alu_sel        = wb.alu_valid_i && (wb.alu_rd_i != '0);

  // ---- stage p0: fixed-priority selection ----
  always_comb begin
    sel_vld_p0  = 1'b0;
    sel_lsu_p0  = 1'b0;
    sel_addr_p0 = '0;
    sel_data_p0 = '0;
    pop         = 1'b0;
    if (alu_sel) begin
      sel_vld_p0  = 1'b1;
      sel_addr_p0 = wb.alu_rd_i;
      sel_data_p0 = wb.alu_data_i;
    end else if (!fifo_empty) begin
      pop         = 1'b1;
      sel_vld_p0  = 1'b1;
      sel_lsu_p0  = 1'b1;
      sel_addr_p0 = fifo_rd[rd_ptr[PTR_W-1:0]];
      sel_data_p0 = fifo_data[rd_ptr[PTR_W-1:0]];
    end else if (lsu_keep) begin
      sel_vld_p0  = 1'b1;
      sel_lsu_p0  = 1'b1;
      sel_addr_p0 = wb.lsu_rd_i;
      sel_data_p0 = wb.lsu_data_i;
    end
  end

  // Anything accepted but not bypassed must queue behind older loads
  assign push = lsu_keep && (alu_sel || !fifo_empty);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd[wr_ptr[PTR_W-1:0]]   <= wb.lsu_rd_i;
      fifo_data[wr_ptr[PTR_W-1:0]] <= wb.lsu_data_i;
    end
  end

  // ---- stage p1: registered write port ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= sel_vld_p0;
      if (sel_vld_p0) begin
        addr_p1 <= sel_addr_p0;
        data_p1 <= sel_data_p0;
      end
    end
  end

  assign wb.wpc_we_o   = vld_p1;
  assign wb.wpc_addr_o = addr_p1;
  assign wb.wpc_data_o = data_p1;

  // Scoreboard: OR-ing the set after the clear makes a same-cycle set win
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (wb.ld_issue_i && (wb.ld_issue_rd_i != '0))
      set_mask[wb.ld_issue_rd_i] = 1'b1;
    if (sel_vld_p0 && sel_lsu_p0)
      clr_mask[sel_addr_p0] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q    <= (busy_q & ~clr_mask) | set_mask;
      busy_q[0] <= 1'b0;
    end
  end

  assign wb.busy_o = busy_q;
endmodule
